pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl_if.sv | 74 +++++++
 rtl/pipe_stall_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// ============================================================================
//  Module      : pipe_stall_ctrl_if
//  Description : Bundle of stall requests, branch/exception redirects,
//                decode hints and stall/flush/redirect controls exchanged
//                between the pipeline and the stall controller.
//                Optional macro PIPE_CTRL_PERF_EN adds performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stall_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_LANES  = 2,
  parameter int ADDR_WIDTH = 32
);

  // Stall requests (level)
  logic                            icache_stall_req;
  logic                            dcache_stall_req;
  logic                            hazard_stall_req;
  logic                            ex_stall_req;

  // Branch mispredicts and exception commit
  logic [NUM_LANES-1:0]            ex_branch_flag;
  logic [NUM_LANES*ADDR_WIDTH-1:0] ex_branch_pc;
  logic                            csr_excp_flag;
  logic [ADDR_WIDTH-1:0]           csr_excp_pc;

  // Decode hints and pipeline status
  logic [NUM_LANES-1:0]            decode_wfi;
  logic [NUM_LANES-1:0]            decode_fence;
  logic                            wakeup;
  logic                            mem_busy;
  logic                            fetch_ready;

  // Controller outputs
  logic [NUM_STAGES-1:0]           stall;
  logic [NUM_STAGES-2:0]           flush;
  logic [NUM_LANES-1:0]            lane_kill;
  logic                            redirect_valid;
  logic [ADDR_WIDTH-1:0]           redirect_pc;
  logic [1:0]                      ctrl_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]                     perf_stall_cnt;
  logic [31:0]                     perf_flush_cnt;
  logic [31:0]                     perf_fence_cnt;
`endif

  // Pipeline side: drives requests, receives controls
  modport master (
    output icache_stall_req, dcache_stall_req, hazard_stall_req, ex_stall_req,
    output ex_branch_flag, ex_branch_pc, csr_excp_flag, csr_excp_pc,
    output decode_wfi, decode_fence, wakeup, mem_busy, fetch_ready,
    input  stall, flush, lane_kill, redirect_valid, redirect_pc, ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt, perf_fence_cnt
`endif
  );

  // Controller side: receives requests, drives controls
  modport slave (
    input  icache_stall_req, dcache_stall_req, hazard_stall_req, ex_stall_req,
    input  ex_branch_flag, ex_branch_pc, csr_excp_flag, csr_excp_pc,
    input  decode_wfi, decode_fence, wakeup, mem_busy, fetch_ready,
    output stall, flush, lane_kill, redirect_valid, redirect_pc, ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt, perf_fence_cnt
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Pipeline stall/flush controller. Arbitrates stall sources by
//                priority, inserts bubbles at the first non-held boundary,
//                resolves multi-lane branch mispredicts and exceptions into
//                flush, lane kill and a registered fetch redirect, and runs a
//                RUN/FENCE/WFI state machine.
//                Optional macro PIPE_CTRL_PERF_EN adds 32-bit perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_LANES  = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_stall_ctrl_if.slave  bus
);

  // Stage indices
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  // Controller states
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FENCE = 2'd1;
  localparam logic [1:0] ST_WFI   = 2'd2;

  logic [1:0]            rState;
  logic [1:0]            wNextState;

  logic [NUM_STAGES-1:0] wStall;
  logic [NUM_STAGES-2:0] wBubble;
  logic [NUM_STAGES-2:0] wCtrlFlush;
  logic [NUM_LANES-1:0]  wBranchKill;
  logic [NUM_LANES-1:0]  wLaneKill;
  logic [ADDR_WIDTH-1:0] wBranchPc;
  logic                  wBranchAny;
  logic                  wRedirectEvent;
  logic [ADDR_WIDTH-1:0] wRedirectTarget;

  logic                  rRedirectValid;
  logic [ADDR_WIDTH-1:0] rRedirectPc;

  assign wBranchAny     = |bus.ex_branch_flag;
  assign wRedirectEvent = bus.csr_excp_flag | wBranchAny;
  // Exception vector beats any branch target raised in the same cycle
  assign wRedirectTarget = bus.csr_excp_flag ? bus.csr_excp_pc : wBranchPc;

  // Next-state selection; a committing exception always returns to RUN
  always_comb begin
    wNextState = rState;
    case (rState)
      ST_RUN: begin
        if (|bus.decode_wfi && !bus.wakeup) begin
          wNextState = ST_WFI;
        end else if (|bus.decode_fence && bus.mem_busy) begin
          wNextState = ST_FENCE;
        end
      end
      ST_FENCE: begin
        if (!bus.mem_busy) begin
          wNextState = ST_RUN;
        end
      end
      ST_WFI: begin
        if (bus.wakeup) begin
          wNextState = ST_RUN;
        end
      end
      default: wNextState = ST_RUN;
    endcase
    if (bus.csr_excp_flag) begin
      wNextState = ST_RUN;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      rState <= ST_RUN;
    end else begin
      rState <= wNextState;
    end
  end

  // Priority stall arbitration; the winner bubbles the boundary just past
  // the deepest stage it holds so that stage does not advance a duplicate
  always_comb begin
    wStall  = '0;
    wBubble = '0;
    if (rState == ST_WFI) begin
      wStall = '1;
    end else if (bus.hazard_stall_req) begin
      for (int k = 0; k < NUM_STAGES; k++) wStall[k] = (k <= STG_ID);
      wBubble[STG_ID] = 1'b1;
    end else if (bus.dcache_stall_req || (rState == ST_FENCE)) begin
      for (int k = 0; k < NUM_STAGES; k++) wStall[k] = (k <= STG_MEM);
      wBubble[STG_MEM] = 1'b1;
    end else if (bus.ex_stall_req) begin
      for (int k = 0; k < NUM_STAGES; k++) wStall[k] = (k <= STG_EX);
      wBubble[STG_EX] = 1'b1;
    end else if (bus.icache_stall_req) begin
      wStall[STG_IF]  = 1'b1;
      wBubble[STG_IF] = 1'b1;
    end
  end

  // Oldest mispredicting lane wins; every younger lane is killed
  always_comb begin
    logic seen;
    seen        = 1'b0;
    wBranchKill = '0;
    wBranchPc   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      wBranchKill[i] = seen;
      if (bus.ex_branch_flag[i] && !seen) begin
        wBranchPc = bus.ex_branch_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      seen = seen | bus.ex_branch_flag[i];
    end
  end

  // Control-flow flush: exception clears through EX, branch through ID
  always_comb begin
    wCtrlFlush = '0;
    wLaneKill  = '0;
    if (bus.csr_excp_flag) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) wCtrlFlush[k] = (k <= STG_EX);
      wLaneKill = '1;
    end else if (wBranchAny) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) wCtrlFlush[k] = (k <= STG_ID);
      wLaneKill = wBranchKill;
    end
  end

  // Combinational controls are forced quiet while reset is held
  assign bus.stall     = rst ? '0 : wStall;
  assign bus.flush     = rst ? '0 : (wBubble | wCtrlFlush);
  assign bus.lane_kill = rst ? '0 : wLaneKill;

  // Redirect register: a new event (re)loads the target, otherwise the
  // request holds until fetch accepts it
  always_ff @(posedge clk) begin
    if (rst) begin
      rRedirectValid <= 1'b0;
      rRedirectPc    <= '0;
    end else if (wRedirectEvent) begin
      rRedirectValid <= 1'b1;
      rRedirectPc    <= wRedirectTarget;
    end else if (rRedirectValid && bus.fetch_ready) begin
      rRedirectValid <= 1'b0;
    end
  end

  assign bus.redirect_valid = rRedirectValid;
  assign bus.redirect_pc    = rRedirectPc;
  assign bus.ctrl_state     = rState;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] rPerfStallCnt;
  logic [31:0] rPerfFlushCnt;
  logic [31:0] rPerfFenceCnt;

  // Free-running event counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      rPerfStallCnt <= '0;
      rPerfFlushCnt <= '0;
      rPerfFenceCnt <= '0;
    end else begin
      if (|wStall)            rPerfStallCnt <= rPerfStallCnt + 32'd1;
      if (wRedirectEvent)     rPerfFlushCnt <= rPerfFlushCnt + 32'd1;
      if (rState == ST_FENCE) rPerfFenceCnt <= rPerfFenceCnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = rPerfStallCnt;
  assign bus.perf_flush_cnt = rPerfFlushCnt;
  assign bus.perf_fence_cnt = rPerfFenceCnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Directed self-checking bench for pipe_stall_ctrl
//                (NUM_STAGES=5, NUM_LANES=2, ADDR_WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;
  int   nVec;
  int   nErr;

  pipe_stall_ctrl_if #(.NUM_STAGES(5), .NUM_LANES(2), .ADDR_WIDTH(32)) busIf ();

  pipe_stall_ctrl #(.NUM_STAGES(5), .NUM_LANES(2), .ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    busIf.icache_stall_req = 1'b0;
    busIf.dcache_stall_req = 1'b0;
    busIf.hazard_stall_req = 1'b0;
    busIf.ex_stall_req     = 1'b0;
    busIf.ex_branch_flag   = 2'b00;
    busIf.ex_branch_pc     = 64'h0;
    busIf.csr_excp_flag    = 1'b0;
    busIf.csr_excp_pc      = 32'h0;
    busIf.decode_wfi       = 2'b00;
    busIf.decode_fence     = 2'b00;
    busIf.wakeup           = 1'b0;
    busIf.mem_busy         = 1'b0;
    busIf.fetch_ready      = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    busIf.hazard_stall_req = 1'b1;
    busIf.ex_branch_flag   = 2'b11;
    busIf.csr_excp_flag    = 1'b1;
    busIf.csr_excp_pc      = 32'h80;
    #1;
    nVec++; if (busIf.stall !== 5'b00000) begin nErr++; $display("FAIL reset_stall: got %b expected %b", busIf.stall, 5'b00000); end
    nVec++; if (busIf.flush !== 4'b0000) begin nErr++; $display("FAIL reset_flush: got %b expected %b", busIf.flush, 4'b0000); end
    nVec++; if (busIf.lane_kill !== 2'b00) begin nErr++; $display("FAIL reset_kill: got %b expected %b", busIf.lane_kill, 2'b00); end
    step();
    step();
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL reset_state: got %0d expected 0", busIf.ctrl_state); end
    nVec++; if (busIf.redirect_valid !== 1'b0) begin nErr++; $display("FAIL reset_rvalid: got %b expected 0", busIf.redirect_valid); end
    nVec++; if (busIf.redirect_pc !== 32'h0) begin nErr++; $display("FAIL reset_rpc: got %h expected 0", busIf.redirect_pc); end
    clearInputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_stall_priority();
    // request bits: {icache, dcache, hazard, ex}
    logic [3:0] req   [6] = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0101, 4'b0110};
    logic [4:0] expSt [6] = '{5'b00000, 5'b00001, 5'b00111, 5'b00111, 5'b01111, 5'b00011};
    logic [3:0] expFl [6] = '{4'b0000, 4'b0001, 4'b0100, 4'b0100, 4'b1000, 4'b0010};
    for (int v = 0; v < 6; v++) begin
      busIf.icache_stall_req = req[v][3];
      busIf.dcache_stall_req = req[v][2];
      busIf.hazard_stall_req = req[v][1];
      busIf.ex_stall_req     = req[v][0];
      #1;
      nVec++; if (busIf.stall !== expSt[v]) begin nErr++; $display("FAIL prio_stall[%0d]: got %b expected %b", v, busIf.stall, expSt[v]); end
      nVec++; if (busIf.flush !== expFl[v]) begin nErr++; $display("FAIL prio_flush[%0d]: got %b expected %b", v, busIf.flush, expFl[v]); end
    end
    clearInputs();
    step();
  endtask

  task automatic test_branch();
    busIf.ex_branch_flag = 2'b11;
    busIf.ex_branch_pc   = {32'h200, 32'h100};
    #1;
    nVec++; if (busIf.flush !== 4'b0011) begin nErr++; $display("FAIL br_flush: got %b expected %b", busIf.flush, 4'b0011); end
    nVec++; if (busIf.lane_kill !== 2'b10) begin nErr++; $display("FAIL br_kill: got %b expected %b", busIf.lane_kill, 2'b10); end
    step();
    busIf.ex_branch_flag = 2'b00;
    nVec++; if (busIf.redirect_valid !== 1'b1) begin nErr++; $display("FAIL br_rvalid: got %b expected 1", busIf.redirect_valid); end
    nVec++; if (busIf.redirect_pc !== 32'h100) begin nErr++; $display("FAIL br_rpc: got %h expected 100", busIf.redirect_pc); end
    step();
    nVec++; if (busIf.redirect_valid !== 1'b0) begin nErr++; $display("FAIL br_rclear: got %b expected 0", busIf.redirect_valid); end
    // Only the younger lane mispredicts: nothing younger to kill
    busIf.ex_branch_flag = 2'b10;
    #1;
    nVec++; if (busIf.lane_kill !== 2'b00) begin nErr++; $display("FAIL br1_kill: got %b expected %b", busIf.lane_kill, 2'b00); end
    step();
    busIf.ex_branch_flag = 2'b00;
    nVec++; if (busIf.redirect_pc !== 32'h200) begin nErr++; $display("FAIL br1_rpc: got %h expected 200", busIf.redirect_pc); end
    clearInputs();
    step();
  endtask

  task automatic test_exception();
    busIf.ex_branch_flag = 2'b01;
    busIf.ex_branch_pc   = {32'h200, 32'h100};
    busIf.csr_excp_flag  = 1'b1;
    busIf.csr_excp_pc    = 32'h80;
    #1;
    nVec++; if (busIf.lane_kill !== 2'b11) begin nErr++; $display("FAIL ex_kill: got %b expected %b", busIf.lane_kill, 2'b11); end
    nVec++; if (busIf.flush !== 4'b0111) begin nErr++; $display("FAIL ex_flush: got %b expected %b", busIf.flush, 4'b0111); end
    step();
    clearInputs();
    nVec++; if (busIf.redirect_valid !== 1'b1) begin nErr++; $display("FAIL ex_rvalid: got %b expected 1", busIf.redirect_valid); end
    nVec++; if (busIf.redirect_pc !== 32'h80) begin nErr++; $display("FAIL ex_rpc: got %h expected 80", busIf.redirect_pc); end
    step();
  endtask

  task automatic test_fence();
    busIf.decode_fence = 2'b01;
    busIf.mem_busy     = 1'b1;
    step();
    busIf.decode_fence = 2'b00;
    for (int c = 0; c < 3; c++) begin
      nVec++; if (busIf.ctrl_state !== 2'd1) begin nErr++; $display("FAIL fence_state[%0d]: got %0d expected 1", c, busIf.ctrl_state); end
      nVec++; if (busIf.stall !== 5'b01111) begin nErr++; $display("FAIL fence_stall[%0d]: got %b expected %b", c, busIf.stall, 5'b01111); end
      nVec++; if (busIf.flush !== 4'b1000) begin nErr++; $display("FAIL fence_flush[%0d]: got %b expected %b", c, busIf.flush, 4'b1000); end
      if (c == 2) busIf.mem_busy = 1'b0;
      step();
    end
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL fence_exit: got %0d expected 0", busIf.ctrl_state); end
    // Fence with memory idle: no state change, no stall
    busIf.decode_fence = 2'b10;
    #1;
    nVec++; if (busIf.stall !== 5'b00000) begin nErr++; $display("FAIL fence_idle_stall: got %b expected %b", busIf.stall, 5'b00000); end
    step();
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL fence_idle_state: got %0d expected 0", busIf.ctrl_state); end
    clearInputs();
    step();
  endtask

  task automatic test_wfi();
    busIf.decode_wfi = 2'b01;
    step();
    busIf.decode_wfi = 2'b00;
    for (int c = 0; c < 10; c++) begin
      nVec++; if (busIf.stall !== 5'b11111) begin nErr++; $display("FAIL wfi_stall[%0d]: got %b expected %b", c, busIf.stall, 5'b11111); end
      step();
    end
    nVec++; if (busIf.ctrl_state !== 2'd2) begin nErr++; $display("FAIL wfi_state: got %0d expected 2", busIf.ctrl_state); end
    nVec++; if (busIf.flush !== 4'b0000) begin nErr++; $display("FAIL wfi_flush: got %b expected %b", busIf.flush, 4'b0000); end
    busIf.wakeup = 1'b1;
    step();
    busIf.wakeup = 1'b0;
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL wfi_wake: got %0d expected 0", busIf.ctrl_state); end
    // Exception while sleeping
    busIf.decode_wfi = 2'b10;
    step();
    busIf.decode_wfi    = 2'b00;
    busIf.csr_excp_flag = 1'b1;
    busIf.csr_excp_pc   = 32'h40;
    #1;
    nVec++; if (busIf.flush !== 4'b0111) begin nErr++; $display("FAIL wfi_ex_flush: got %b expected %b", busIf.flush, 4'b0111); end
    step();
    busIf.csr_excp_flag = 1'b0;
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL wfi_ex_state: got %0d expected 0", busIf.ctrl_state); end
    nVec++; if (busIf.redirect_valid !== 1'b1) begin nErr++; $display("FAIL wfi_ex_rvalid: got %b expected 1", busIf.redirect_valid); end
    nVec++; if (busIf.redirect_pc !== 32'h40) begin nErr++; $display("FAIL wfi_ex_rpc: got %h expected 40", busIf.redirect_pc); end
    // Fence and WFI together: WFI wins
    busIf.decode_wfi   = 2'b01;
    busIf.decode_fence = 2'b01;
    busIf.mem_busy     = 1'b1;
    step();
    clearInputs();
    nVec++; if (busIf.ctrl_state !== 2'd2) begin nErr++; $display("FAIL wfi_vs_fence: got %0d expected 2", busIf.ctrl_state); end
    busIf.wakeup = 1'b1;
    step();
    clearInputs();
    step();
  endtask

  task automatic test_redirect_hold();
    busIf.fetch_ready    = 1'b0;
    busIf.ex_branch_flag = 2'b01;
    busIf.ex_branch_pc   = {32'h0, 32'h300};
    step();
    busIf.ex_branch_flag = 2'b00;
    for (int c = 0; c < 4; c++) begin
      nVec++; if (busIf.redirect_valid !== 1'b1 || busIf.redirect_pc !== 32'h300) begin
        nErr++; $display("FAIL hold[%0d]: got %b/%h expected 1/300", c, busIf.redirect_valid, busIf.redirect_pc);
      end
      step();
    end
    busIf.fetch_ready = 1'b1;
    step();
    nVec++; if (busIf.redirect_valid !== 1'b0) begin nErr++; $display("FAIL hold_clear: got %b expected 0", busIf.redirect_valid); end
    // Overwrite a pending redirect; exception beats the simultaneous branch
    busIf.fetch_ready    = 1'b0;
    busIf.ex_branch_flag = 2'b01;
    step();
    busIf.csr_excp_flag  = 1'b1;
    busIf.csr_excp_pc    = 32'h500;
    step();
    busIf.ex_branch_flag = 2'b00;
    busIf.csr_excp_flag  = 1'b0;
    nVec++; if (busIf.redirect_valid !== 1'b1 || busIf.redirect_pc !== 32'h500) begin
      nErr++; $display("FAIL overwrite: got %b/%h expected 1/500", busIf.redirect_valid, busIf.redirect_pc);
    end
    clearInputs();
    step();
  endtask

  task automatic test_reset_midop();
    busIf.fetch_ready    = 1'b0;
    busIf.ex_branch_flag = 2'b01;
    busIf.ex_branch_pc   = {32'h0, 32'h700};
    busIf.decode_fence   = 2'b01;
    busIf.mem_busy       = 1'b1;
    step();
    busIf.ex_branch_flag = 2'b00;
    busIf.decode_fence   = 2'b00;
    nVec++; if (busIf.ctrl_state !== 2'd1 || busIf.redirect_valid !== 1'b1) begin
      nErr++; $display("FAIL midop_setup: got %0d/%b expected 1/1", busIf.ctrl_state, busIf.redirect_valid);
    end
    rst = 1'b1;
    busIf.dcache_stall_req = 1'b1;
    #1;
    nVec++; if (busIf.stall !== 5'b00000 || busIf.flush !== 4'b0000) begin
      nErr++; $display("FAIL midop_comb: got %b/%b expected 00000/0000", busIf.stall, busIf.flush);
    end
    step();
    nVec++; if (busIf.ctrl_state !== 2'd0) begin nErr++; $display("FAIL midop_state: got %0d expected 0", busIf.ctrl_state); end
    nVec++; if (busIf.redirect_valid !== 1'b0) begin nErr++; $display("FAIL midop_rvalid: got %b expected 0", busIf.redirect_valid); end
`ifdef PIPE_CTRL_PERF_EN
    nVec++; if (busIf.perf_stall_cnt !== 32'd0 || busIf.perf_flush_cnt !== 32'd0 || busIf.perf_fence_cnt !== 32'd0) begin
      nErr++; $display("FAIL midop_perf: got %0d/%0d/%0d expected 0/0/0", busIf.perf_stall_cnt, busIf.perf_flush_cnt, busIf.perf_fence_cnt);
    end
`endif
    rst = 1'b0;
    clearInputs();
    step();
    nVec++; if (busIf.ctrl_state !== 2'd0 || busIf.redirect_valid !== 1'b0) begin
      nErr++; $display("FAIL midop_after: got %0d/%b expected 0/0", busIf.ctrl_state, busIf.redirect_valid);
    end
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    rst  = 1'b1;
    clearInputs();
    #1;
    test_reset();
    test_stall_priority();
    test_branch();
    test_exception();
    test_fence();
    test_wfi();
    test_redirect_hold();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

`default_nettype wire
